// File: rtl/touch_pkt_uart_tx.sv
// touch_pkt_uart_tx: serialises pen events into the 5-byte AR1100-style pen
// packet on an 8N1, LSB-first UART line (idle high). One event is accepted per
// packet over a valid/ready handshake; coordinates are latched on acceptance.
module touch_pkt_uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [11:0] pkt_x,
    input  logic [11:0] pkt_y,
    input  logic        pkt_pen,
    output logic        txd,
    output logic        busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Packet byte selected by its position within the 5-byte pen packet.
    function automatic logic [7:0] pkt_byte(
        input logic [2:0]  idx,
        input logic        pen,
        input logic [11:0] x,
        input logic [11:0] y
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = {1'b1, 6'b000000, pen};
            3'd1:    b = {1'b0, x[6:0]};
            3'd2:    b = {3'b000, x[11:7]};
            3'd3:    b = {1'b0, y[6:0]};
            3'd4:    b = {3'b000, y[11:7]};
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    state_t        state_q,    state_d;
    logic [CW-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [GW-1:0] gap_cnt_q,  gap_cnt_d;
    logic [11:0]   x_q,        x_d;
    logic [11:0]   y_q,        y_d;
    logic          pen_q,      pen_d;
    logic          txd_q,      txd_d;
    logic          ready_q,    ready_d;
    logic          busy_q,     busy_d;

    logic [7:0]    cur_byte_s;
    logic          bit_end_s;

    assign cur_byte_s = pkt_byte(byte_idx_q, pen_q, x_q, y_q);
    assign bit_end_s  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

    // Next-state logic: txd_d is the line level for the next cycle, so the
    // registered txd changes exactly on state/bit boundaries.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        pen_d      = pen_q;
        txd_d      = txd_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid && ready_q) begin
                    x_d        = pkt_x;
                    y_d        = pkt_y;
                    pen_d      = pkt_pen;
                    byte_idx_d = 3'd0;
                    clk_cnt_d  = '0;
                    txd_d      = 1'b0;
                    ready_d    = 1'b0;
                    state_d    = S_START;
                end else begin
                    txd_d      = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    txd_d     = cur_byte_s[0];
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = cur_byte_s[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q != 3'd4) begin
                        // Next byte starts immediately: no idle between frames.
                        byte_idx_d = byte_idx_q + 3'd1;
                        txd_d      = 1'b0;
                        state_d    = S_START;
                    end else if (GAP_BITS > 0) begin
                        gap_cnt_d = '0;
                        txd_d     = 1'b1;
                        state_d   = S_GAP;
                    end else begin
                        txd_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (bit_end_s) begin
                    clk_cnt_d = '0;
                    if (gap_cnt_q == GW'(GAP_BITS - 1)) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = ~ready_d;
    end

    // State and output registers; reset forces the line idle high immediately.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            gap_cnt_q  <= '0;
            x_q        <= 12'd0;
            y_q        <= 12'd0;
            pen_q      <= 1'b0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pen_q      <= pen_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign txd       = txd_q;
    assign pkt_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_touch_pkt_uart_tx.sv
// Bench for touch_pkt_uart_tx: two instances (GAP_BITS=1 and GAP_BITS=0),
// UART monitors decode mid-bit and pop expected bytes from scoreboards.
module tb_touch_pkt_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, ready_a, pen_a, txd_a, busy_a;
    logic [11:0] x_a, y_a;
    logic        valid_b, ready_b, pen_b, txd_b, busy_b;
    logic [11:0] x_b, y_b;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rst_gen = 0;
    int          seen_a = 0;
    int          seen_b = 0;
    int          last_start_b = -1;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    int          start_a[$];

    always #5 clk = ~clk;

    // Cycle index: at a negedge it equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    touch_pkt_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(1)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .pkt_valid(valid_a), .pkt_ready(ready_a),
        .pkt_x(x_a), .pkt_y(y_a), .pkt_pen(pen_a),
        .txd(txd_a), .busy(busy_a)
    );

    touch_pkt_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .pkt_valid(valid_b), .pkt_ready(ready_b),
        .pkt_x(x_b), .pkt_y(y_b), .pkt_pen(pen_b),
        .txd(txd_b), .busy(busy_b)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_pkt_b(input logic [11:0] x, input logic [11:0] y, input logic pen);
        exp_b.push_back({1'b1, 6'b000000, pen});
        exp_b.push_back({1'b0, x[6:0]});
        exp_b.push_back({3'b000, x[11:7]});
        exp_b.push_back({1'b0, y[6:0]});
        exp_b.push_back({3'b000, y[11:7]});
    endfunction

    function automatic void push5_a(input logic [39:0] bytes);
        for (int i = 4; i >= 0; i--) exp_a.push_back(bytes[i*8 +: 8]);
    endfunction

    function automatic logic line(input int ch);
        return (ch == 0) ? txd_a : txd_b;
    endfunction

    // UART monitor: detects a start bit, samples each bit at its middle.
    task automatic uart_mon(input int ch);
        logic [7:0] d;
        logic       sb, pb;
        int         sc, g;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || line(ch) !== 1'b0) continue;
            sc = cyc;
            g  = rst_gen;
            repeat (CPB / 2) @(negedge clk);
            sb = line(ch);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = line(ch);
            end
            repeat (CPB) @(negedge clk);
            pb = line(ch);
            if (g != rst_gen) continue;
            chk(ch == 0 ? "start_bit_a" : "start_bit_b", sb, 1'b0);
            chk(ch == 0 ? "stop_bit_a" : "stop_bit_b", pb, 1'b1);
            if (ch == 0) begin
                if (exp_a.size() == 0) chk("unexpected_byte_a", d, 32'hFFFF_FFFF);
                else chk("byte_a", d, exp_a.pop_front());
                start_a.push_back(sc);
                seen_a++;
            end else begin
                if (exp_b.size() == 0) chk("unexpected_byte_b", d, 32'hFFFF_FFFF);
                else chk("byte_b", d, exp_b.pop_front());
                // 40 cycles per frame; one IDLE accept cycle between packets.
                if (seen_b > 0) chk("spacing_b", sc - last_start_b, (seen_b % 5 == 0) ? 41 : 40);
                last_start_b = sc;
                seen_b++;
            end
        end
    endtask

    initial uart_mon(0);
    initial uart_mon(1);

    task automatic wait_ready_a(output int t);
        int w;
        w = 0;
        while (ready_a !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("ready_a_timeout", ready_a, 1'b1);
        t = cyc;
    endtask

    // Offer one event on instance A; t0 is the first start-bit cycle.
    task automatic send_a(input logic [11:0] x, input logic [11:0] y, input logic pen,
                          input bit hold, output int t0);
        int t;
        @(negedge clk);
        x_a = x; y_a = y; pen_a = pen; valid_a = 1'b1;
        wait_ready_a(t);
        @(posedge clk);
        #1;
        if (!hold) valid_a = 1'b0;
        @(negedge clk);
        t0 = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0, t1, n, w;
        bit  ok;
        logic [11:0] xi, yi;

        rst_n = 1'b0;
        valid_a = 1'b0; x_a = 12'd0; y_a = 12'd0; pen_a = 1'b0;
        valid_b = 1'b0; x_b = 12'd0; y_b = 12'd0; pen_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd_a, 1'b1);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        rst_n = 1'b1;

        // 1: idle after reset release
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 ||
                txd_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0) ok = 1'b0;
        end
        chk("idle_100_cycles", ok, 1'b1);

        // 2: x=9A5 y=123 pen=1
        start_a.delete();
        push5_a(40'h81_25_13_23_02);
        send_a(12'h9A5, 12'h123, 1'b1, 1'b0, t0);
        chk("busy_during_pkt", busy_a, 1'b1);
        chk("ready_low_during_pkt", ready_a, 1'b0);
        wait_ready_a(t1);
        chk("ready_latency", t1 - t0, 204);
        chk("busy_after_pkt", busy_a, 1'b0);
        repeat (4) @(negedge clk);
        chk("first_start_cycle", (start_a.size() > 0) ? start_a[0] : -1, t0);
        chk("pkt2_drained", exp_a.size(), 0);

        // 3: pen up, x=FFF y=000
        push5_a(40'h80_7F_1F_00_00);
        send_a(12'hFFF, 12'h000, 1'b0, 1'b0, t0);
        wait_ready_a(t1);
        chk("ready_latency_3", t1 - t0, 204);
        repeat (4) @(negedge clk);
        chk("pkt3_drained", exp_a.size(), 0);

        // 4: valid held, inputs changed mid-packet
        start_a.delete();
        push5_a(40'h81_37_05_4E_18);
        push5_a(40'h80_7F_00_00_1F);
        send_a(12'h2B7, 12'hC4E, 1'b1, 1'b1, t0);
        x_a = 12'h07F; y_a = 12'hF80; pen_a = 1'b0;
        wait_ready_a(t1);
        chk("ready_latency_4", t1 - t0, 204);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(negedge clk);
        wait_ready_a(t1);
        repeat (4) @(negedge clk);
        chk("stream_bytes", start_a.size(), 10);
        if (start_a.size() >= 6) begin
            // 4 gap cycles plus the single IDLE cycle in which the next packet is taken.
            chk("stream_idle_run", start_a[5] - (start_a[4] + 40), 4 * 1 + 1);
            chk("stream_second_start", start_a[5] - t0, 205);
        end
        chk("pkt4_drained", exp_a.size(), 0);

        // 5: reset during B2
        push5_a(40'h81_25_13_23_02);
        send_a(12'h9A5, 12'h123, 1'b1, 1'b0, t0);
        repeat (80) @(negedge clk);
        chk("b2_start_low", txd_a, 1'b0);
        rst_gen++;
        rst_n = 1'b0;
        #1;
        chk("rst_async_txd", txd_a, 1'b1);
        chk("rst_async_ready", ready_a, 1'b1);
        chk("rst_async_busy", busy_a, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = seen_a;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || ready_a !== 1'b1) ok = 1'b0;
        end
        chk("post_rst_quiet", ok, 1'b1);
        chk("post_rst_no_bytes", seen_a - n, 0);
        chk("post_rst_remaining", exp_a.size(), 3);
        exp_a.delete();

        // 6: GAP_BITS=0 instance streaming 20 packets
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            xi = 12'(i * 173 + 5);
            yi = 12'(4095 - i * 97);
            x_b = xi; y_b = yi; pen_b = i[0]; valid_b = 1'b1;
            push_pkt_b(xi, yi, i[0]);
            w = 0;
            while (ready_b !== 1'b1 && w < 1000) begin
                @(negedge clk);
                w++;
            end
            chk("accept_b", ready_b, 1'b1);
            @(posedge clk);
        end
        #1;
        valid_b = 1'b0;
        w = 0;
        while ((exp_b.size() != 0 || ready_b !== 1'b1) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        chk("stream_b_count", seen_b, 100);
        chk("stream_b_drained", exp_b.size(), 0);
        chk("final_a_drained", exp_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
